// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit state encoding.
// Used by the RGMII transmitter and the receive-side FCS checker.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) update for one byte, LSB of d first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rgmii_tx.sv
// RGMII frame transmitter: preamble, SFD, buffered payload, zero pad, FCS, IFG.
// One byte per txclk; the DDR output stage sends txd_p on rise, txd_n on fall.
module rgmii_tx
    import eth_pkg::*;
#(
    parameter int PRE_LEN = 7,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1500,
    parameter int IFG_LEN = 12
) (
    input  logic        txclk,
    input  logic        rstn,
    input  logic        start,
    input  logic [13:0] len,
    output logic [13:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        txctl,
    output logic [3:0]  txd_p,
    output logic [3:0]  txd_n,
    output logic        busy,
    output logic        done
);

    localparam logic [13:0] PRE_LAST = 14'(PRE_LEN - 1);
    localparam logic [13:0] MIN_L    = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L    = 14'(MAX_LEN);
    localparam logic [13:0] IFG_LAST = 14'(IFG_LEN - 1);
    localparam logic [13:0] IFG_END  = 14'(IFG_LEN);

    tx_state_t   state_reg;
    logic [13:0] cnt_reg;
    logic [13:0] len_reg;
    logic [13:0] rd_addr_reg;
    logic [31:0] crc_reg;
    logic [7:0]  byte_reg;
    logic        txctl_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [31:0] crc_next;
    logic [7:0]  crc_din;
    logic [7:0]  fcs_byte;
    logic [31:0] fcs;
    logic [13:0] pad_last;

    assign crc_din  = (state_reg == DATA) ? rd_data : 8'h00;
    assign fcs      = ~crc_reg;
    assign pad_last = MIN_L - len_reg - 14'd1;

    crc32_d8 u_crc (
        .crc_in  (crc_reg),
        .d       (crc_din),
        .crc_out (crc_next)
    );

    always_comb begin
        fcs_byte = fcs[7:0];
        unique case (cnt_reg[1:0])
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
        endcase
    end

    always_ff @(posedge txclk) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            rd_addr_reg <= '0;
            crc_reg     <= CRC_INIT;
            byte_reg    <= '0;
            txctl_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    txctl_reg <= 1'b0;
                    byte_reg  <= '0;
                    if (start) begin
                        len_reg     <= (len > MAX_L) ? MAX_L : len;
                        cnt_reg     <= '0;
                        rd_addr_reg <= '0;
                        crc_reg     <= CRC_INIT;
                        busy_reg    <= 1'b1;
                        txctl_reg   <= 1'b1;
                        byte_reg    <= PREAMBLE;
                        state_reg   <= PRE;
                    end
                end
                PRE: begin
                    cnt_reg <= cnt_reg + 14'd1;
                    if (cnt_reg == PRE_LAST) begin
                        // Address 0 has been held through the preamble, so byte 0 is
                        // already on rd_data; step ahead to keep the read one byte early.
                        byte_reg    <= SFD;
                        cnt_reg     <= '0;
                        rd_addr_reg <= {13'd0, len_reg > 14'd1};
                        if (len_reg != 14'd0)
                            state_reg <= DATA;
                        else if (len_reg < MIN_L)
                            state_reg <= PAD;
                        else
                            state_reg <= FCS;
                    end else begin
                        byte_reg <= PREAMBLE;
                    end
                end
                DATA: begin
                    byte_reg <= rd_data;
                    crc_reg  <= crc_next;
                    cnt_reg  <= cnt_reg + 14'd1;
                    if (rd_addr_reg != len_reg - 14'd1)
                        rd_addr_reg <= rd_addr_reg + 14'd1;
                    if (cnt_reg == len_reg - 14'd1) begin
                        cnt_reg   <= '0;
                        state_reg <= (len_reg < MIN_L) ? PAD : FCS;
                    end
                end
                PAD: begin
                    byte_reg <= 8'h00;
                    crc_reg  <= crc_next;
                    cnt_reg  <= cnt_reg + 14'd1;
                    if (cnt_reg == pad_last) begin
                        cnt_reg   <= '0;
                        state_reg <= FCS;
                    end
                end
                FCS: begin
                    byte_reg <= fcs_byte;
                    cnt_reg  <= cnt_reg + 14'd1;
                    if (cnt_reg[1:0] == 2'd3) begin
                        cnt_reg   <= '0;
                        state_reg <= IFG;
                    end
                end
                IFG: begin
                    txctl_reg <= 1'b0;
                    byte_reg  <= '0;
                    cnt_reg   <= cnt_reg + 14'd1;
                    if (cnt_reg == IFG_LAST)
                        done_reg <= 1'b1;
                    if (cnt_reg == IFG_END) begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_addr = rd_addr_reg;
    assign txctl   = txctl_reg;
    assign txd_p   = byte_reg[3:0];
    assign txd_n   = byte_reg[7:4];
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_rgmii_tx.sv
// Directed/randomised bench for rgmii_tx against a byte-list frame model.
module tb_rgmii_tx;

    logic        clk;
    logic        rstn;
    logic        start_a, start_b;
    logic [13:0] len_v;
    logic [13:0] rd_addr_a, rd_addr_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        txctl_a, txctl_b;
    logic [3:0]  txd_p_a, txd_n_a, txd_p_b, txd_n_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [7:0]  mem [0:16383];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          ndone, gap, maxaddr, nz;

    rgmii_tx dut_a (
        .txclk(clk), .rstn(rstn), .start(start_a), .len(len_v),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .txctl(txctl_a),
        .txd_p(txd_p_a), .txd_n(txd_n_a), .busy(busy_a), .done(done_a)
    );

    rgmii_tx #(.MIN_LEN(0)) dut_b (
        .txclk(clk), .rstn(rstn), .start(start_b), .len(len_v),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .txctl(txctl_b),
        .txd_p(txd_p_b), .txd_n(txd_n_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame buffer, one cycle of read latency.
    always @(posedge clk) begin
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Expected on-wire bytes: preamble, SFD, clamped payload, zero pad, ~CRC LSB first.
    task automatic build_exp(input int n, input int minlen);
        int L;
        logic [31:0] c;
        L = (n > 1500) ? 1500 : n;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < L; i++) exp_q.push_back(mem[i]);
        for (int i = L; i < minlen; i++) exp_q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic set_start(input bit which, input logic v);
        if (which) start_b = v; else start_a = v;
    endtask

    // Optionally launches a frame, then samples each negedge until done (or a bound).
    task automatic run(input bit which, input bit do_start, input int n, input int poke_at,
                       input int hold_at, input int rst_at, input int budget);
        logic       ctl, bsy, dn;
        logic [7:0] bv;
        int         addr, zrun;
        bit         finished;
        got_q.delete();
        ndone = 0; gap = -1; maxaddr = 0; nz = 0; zrun = 0; finished = 0;
        if (do_start) begin
            @(negedge clk);
            len_v = 14'(n);
            set_start(which, 1'b1);
            @(negedge clk);
            set_start(which, 1'b0);
            ctl = which ? txctl_b : txctl_a;
            bsy = which ? busy_b : busy_a;
            bv  = which ? {txd_n_b, txd_p_b} : {txd_n_a, txd_p_a};
            chk("accept", {ctl, bv, bsy}, {1'b1, 8'h55, 1'b1});
        end
        for (int cyc = 0; cyc <= budget; cyc++) begin
            ctl  = which ? txctl_b : txctl_a;
            bsy  = which ? busy_b : busy_a;
            dn   = which ? done_b : done_a;
            bv   = which ? {txd_n_b, txd_p_b} : {txd_n_a, txd_p_a};
            addr = which ? int'(rd_addr_b) : int'(rd_addr_a);
            if (ctl) begin
                got_q.push_back(bv);
                zrun = 0;
            end else begin
                zrun++;
                if (bv !== 8'h00) nz++;
            end
            if (bsy && addr > maxaddr) maxaddr = addr;
            if (dn) begin
                ndone++;
                gap = zrun;
            end
            if (poke_at >= 0 && cyc == poke_at) begin
                len_v = 14'd7;
                set_start(which, 1'b1);
            end
            if (poke_at >= 0 && cyc == poke_at + 1) set_start(which, 1'b0);
            if (hold_at >= 0 && cyc == hold_at) begin
                len_v = 14'd10;
                set_start(which, 1'b1);
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                chk("rst_cut", {ctl, bsy, dn}, 3'b000);
                rstn = 1'b1;
            end
            if (rst_at >= 0 && cyc == rst_at) rstn = 1'b0;
            if (dn && rst_at < 0) begin
                finished = 1;
                break;
            end
            if (rst_at >= 0 && cyc == rst_at + 20) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        if (!finished) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic check_frame(input string tag);
        int          bad;
        logic [7:0]  ob, eb;
        logic [31:0] c;
        bad = -1; ob = 8'h00; eb = 8'h00;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== exp_q[i]) begin
                bad = i; ob = got_q[i]; eb = exp_q[i];
            end
        end
        $display("[TB] frame %s: %0d bytes with txctl high, %0d expected", tag, got_q.size(), exp_q.size());
        chk({tag, "_txctl_cycles"}, 64'(got_q.size()), 64'(exp_q.size()));
        chk({tag, "_bytes"}, {32'(bad), 16'(0), ob, eb}, {32'hFFFFFFFF, 16'(0), ob, eb});
        c = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) c = crc_upd(c, got_q[i]);
        chk({tag, "_residue"}, 64'(c), 64'(32'hDEBB20E3));
    endtask

    initial begin
        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; len_v = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("reset_a", {txctl_a, txd_p_a, txd_n_a, busy_a, done_a, rd_addr_a}, 25'd0);
        chk("reset_b", {txctl_b, txd_p_b, txd_n_b, busy_b, done_b, rd_addr_b}, 25'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Length 64, buffer holds its own address.
        build_exp(64, 60);
        run(0, 1, 64, -1, -1, -1, 200);
        check_frame("len64");
        chk("len64_ctl76", 64'(got_q.size()), 64'd76);
        chk("len64_done_once", 64'(ndone), 64'd1);
        chk("len64_done_gap", 64'(gap), 64'd12);
        chk("len64_max_addr", 64'(maxaddr), 64'd63);
        chk("len64_idle_zero", 64'(nz), 64'd0);
        @(negedge clk);
        chk("len64_busy_fall", {63'd0, busy_a}, 64'd0);
        repeat (2) @(negedge clk);

        // No minimum length: check value of "123456789".
        for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
        build_exp(9, 0);
        run(1, 1, 9, -1, -1, -1, 100);
        check_frame("crc9");
        chk("crc9_ctl21", 64'(got_q.size()), 64'd21);
        chk("crc9_fcs", {got_q[got_q.size()-4], got_q[got_q.size()-3],
                         got_q[got_q.size()-2], got_q[got_q.size()-1]}, 32'h2639F4CB);
        repeat (2) @(negedge clk);

        // Empty payload: pad only, buffer contents must not leak.
        for (int i = 0; i < 1600; i++) mem[i] = 8'($urandom_range(1, 255));
        build_exp(0, 60);
        run(0, 1, 0, -1, -1, -1, 200);
        check_frame("len0");
        chk("len0_max_addr", 64'(maxaddr), 64'd0);
        repeat (2) @(negedge clk);

        // Short payload with padding, reads bounded by the frame.
        for (int i = 0; i < 1600; i++) mem[i] = 8'($urandom);
        build_exp(20, 60);
        run(0, 1, 20, -1, -1, -1, 200);
        check_frame("len20");
        chk("len20_max_addr", 64'(maxaddr), 64'd19);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 100);
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            build_exp(n, 60);
            run(0, 1, n, -1, -1, -1, 300);
            check_frame($sformatf("rand%0d_len%0d", r, n));
            chk("rand_done_once", 64'(ndone), 64'd1);
            repeat (2) @(negedge clk);
        end

        // Oversize request: clamped, mid-frame start ignored, held start relaunches.
        for (int i = 0; i < 1600; i++) mem[i] = 8'($urandom);
        build_exp(5000, 60);
        run(0, 1, 5000, 100, 1516, -1, 2000);
        check_frame("len5000");
        chk("len5000_ctl1512", 64'(got_q.size()), 64'd1512);
        chk("len5000_done_once", 64'(ndone), 64'd1);
        @(negedge clk);
        chk("hold_idle_cycle", {63'd0, busy_a}, 64'd0);
        @(negedge clk);
        chk("hold_relaunch", {busy_a, txctl_a, txd_n_a, txd_p_a}, {1'b1, 1'b1, 8'h55});
        start_a = 1'b0;
        build_exp(10, 60);
        run(0, 0, 10, -1, -1, -1, 200);
        check_frame("relaunch_len10");
        repeat (2) @(negedge clk);

        // One-cycle reset mid-payload, then a clean frame.
        run(0, 1, 64, -1, -1, 30, 200);
        chk("rst_no_done", 64'(ndone), 64'd0);
        chk("rst_busy_low", {63'd0, busy_a}, 64'd0);
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        build_exp(64, 60);
        run(0, 1, 64, -1, -1, -1, 200);
        check_frame("after_rst");
        chk("after_rst_done_once", 64'(ndone), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
